// File: rtl/nivel_comida_scheduler.sv
// Food-level scheduler for the pet: 1 s prescaler, timed decay, feed acceptance
// with a cooldown window, and a frozen, manually stepped test mode.
module nivel_comida_scheduler #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned DECAY_SECS    = 10,
  parameter int unsigned FEED_COOLDOWN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Boton_Comida,
  input  logic       Activo_Comida,
  input  logic       Senal_MTest,
  input  logic       Senal_Paso,
  output logic [1:0] Nivel_Comida,
  output logic       Pulso_Seg,
  output logic [7:0] Cuenta_Decaimiento,
  output logic       Alimentando,
  output logic       Evento_Comida
);

  localparam int unsigned     PW           = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_ZERO   = PW'(0);
  localparam logic [PW-1:0]   PRESC_ONE    = PW'(1);
  localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [7:0]      DECAY_RELOAD = 8'(DECAY_SECS);
  localparam logic [7:0]      COOL_RELOAD  = 8'(FEED_COOLDOWN);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_FEED = 2'd1,
    S_TEST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    level_q, level_d;
  logic [7:0]    cuenta_q, cuenta_d;
  logic [7:0]    cool_q, cool_d;
  logic          pulso_q, pulso_d;
  logic          alim_q, alim_d;
  logic          evento_q, evento_d;
  logic          boton_hist_q;
  logic          paso_hist_q;

  logic          tick_s;
  logic          feed_edge_s;
  logic          paso_edge_s;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    if (v == 2'd3) return 2'd3;
    else           return v + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    if (v == 2'd0) return 2'd0;
    else           return v - 2'd1;
  endfunction

  // Button history starts at 1 so a button held through reset gives no edge.
  assign feed_edge_s = Boton_Comida & ~boton_hist_q;
  assign paso_edge_s = Senal_Paso & ~paso_hist_q;
  assign tick_s      = (state_q != S_TEST) && (presc_q == PRESC_MAX);

  // Next-state logic: mode transitions, prescaler, decay, feed and test stepping.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    level_d  = level_q;
    cuenta_d = cuenta_q;
    cool_d   = cool_q;
    evento_d = 1'b0;

    case (state_q)
      S_RUN: begin
        presc_d = tick_s ? PRESC_ZERO : presc_q + PRESC_ONE;
        if (Senal_MTest) begin
          state_d = S_TEST;
          presc_d = PRESC_ZERO;
          cool_d  = 8'd0;
        end else if (feed_edge_s && Activo_Comida) begin
          // A feed beats a coincident decay step: the step is simply dropped.
          level_d  = sat_inc(level_q);
          evento_d = 1'b1;
          cuenta_d = DECAY_RELOAD;
          cool_d   = COOL_RELOAD;
          state_d  = S_FEED;
        end else if (tick_s) begin
          if (cuenta_q > 8'd1) begin
            cuenta_d = cuenta_q - 8'd1;
          end else begin
            level_d  = sat_dec(level_q);
            cuenta_d = DECAY_RELOAD;
          end
        end else begin
          state_d = S_RUN;
        end
      end

      S_FEED: begin
        presc_d = tick_s ? PRESC_ZERO : presc_q + PRESC_ONE;
        if (Senal_MTest) begin
          state_d = S_TEST;
          presc_d = PRESC_ZERO;
          cool_d  = 8'd0;
        end else if (tick_s) begin
          cool_d = cool_q - 8'd1;
          if (cool_q == 8'd1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FEED;
          end
        end else begin
          state_d = S_FEED;
        end
      end

      S_TEST: begin
        presc_d = PRESC_ZERO;
        cool_d  = 8'd0;
        if (!Senal_MTest) begin
          state_d  = S_RUN;
          cuenta_d = DECAY_RELOAD;
        end else if (paso_edge_s) begin
          // Deliberate wrap so the tester can cycle through every level.
          level_d = level_q - 2'd1;
        end else begin
          state_d = S_TEST;
        end
      end

      default: begin
        state_d = S_RUN;
        presc_d = PRESC_ZERO;
        cool_d  = 8'd0;
      end
    endcase

    pulso_d = (state_d != S_TEST) && (presc_d == PRESC_MAX);
    alim_d  = (state_d == S_FEED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      presc_q      <= PRESC_ZERO;
      level_q      <= 2'd3;
      cuenta_q     <= DECAY_RELOAD;
      cool_q       <= 8'd0;
      pulso_q      <= 1'b0;
      alim_q       <= 1'b0;
      evento_q     <= 1'b0;
      boton_hist_q <= 1'b1;
      paso_hist_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      level_q      <= level_d;
      cuenta_q     <= cuenta_d;
      cool_q       <= cool_d;
      pulso_q      <= pulso_d;
      alim_q       <= alim_d;
      evento_q     <= evento_d;
      boton_hist_q <= Boton_Comida;
      paso_hist_q  <= Senal_Paso;
    end
  end

  assign Nivel_Comida       = level_q;
  assign Pulso_Seg          = pulso_q;
  assign Cuenta_Decaimiento = cuenta_q;
  assign Alimentando        = alim_q;
  assign Evento_Comida      = evento_q;

endmodule

// File: doc/nivel_comida_scheduler.md
Name: nivel_comida_scheduler

Overview:
- Owns the pet's 2-bit food level (Nivel_Comida) and schedules its changes for the pet state machine.
- Decays the level one step every DECAY_SECS seconds; raises it on a feed press while the pet FSM reports feeding enabled.
- Enforces a feed cooldown window.
- Gives test mode a frozen, manually stepped level.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per 1-second tick (50 MHz board clock); legal >= 2.
- DECAY_SECS, 10: seconds per decay step; legal 1..255.
- FEED_COOLDOWN, 2: seconds of feed lockout after an accepted feed; legal 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Boton_Comida  in  1  debounced feed button, active high
- Activo_Comida  in  1  feed enable from the pet FSM; 1 = feeding allowed
- Senal_MTest  in  1  test mode level; 1 = decay frozen, manual stepping
- Senal_Paso  in  1  debounced test step button, active high
- Nivel_Comida  out  2  current food level, 0..3
- Pulso_Seg  out  1  one-cycle pulse per 1-second tick
- Cuenta_Decaimiento  out  8  seconds remaining to next decay step
- Alimentando  out  1  1 while the cooldown is active
- Evento_Comida  out  1  one-cycle pulse per accepted feed

Behaviour:
- Reset (async assert, sync release), all outputs and state:
  - Nivel_Comida=3, Pulso_Seg=0, Evento_Comida=0, Alimentando=0, Cuenta_Decaimiento=DECAY_SECS.
  - Prescaler=0, cooldown=0, state=S_RUN.
  - Button history registers for Boton_Comida and Senal_Paso reset to 1, so a button held through reset never yields an edge.
- Edge detect:
  - A rising edge is input=1 while its history register=0, sampled at a clk edge.
  - History registers update every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 in S_RUN and S_FEED.
  - Pulso_Seg=1 for exactly the cycle where prescaler==TICK_DIV-1; the prescaler then wraps to 0.
  - In S_TEST the prescaler is held at 0 and Pulso_Seg=0.
- State S_RUN:
  - On a tick: if Cuenta_Decaimiento>1, decrement it. If it is 1, Nivel_Comida = max(Nivel_Comida-1, 0) (saturating) and Cuenta_Decaimiento reloads DECAY_SECS.
  - Feed edge with Activo_Comida=1:
    - Nivel_Comida = min(Nivel_Comida+1, 3); at level 3 it stays 3 but the feed is still accepted.
    - Evento_Comida=1 for one cycle, registered, visible the cycle after the sampling edge.
    - Cuenta_Decaimiento reloads DECAY_SECS; cooldown loads FEED_COOLDOWN; next state S_FEED.
  - Feed edge with Activo_Comida=0: ignored, no output change.
  - Feed edge and decay step in the same cycle: the feed wins. Level = old+1 saturating, the decay step is discarded, and the counter reloads.
- State S_FEED:
  - Alimentando=1; decay is paused and Cuenta_Decaimiento is held.
  - Feed edges are ignored.
  - Each tick decrements the cooldown. The tick that takes it to 0 moves to S_RUN next cycle, where Alimentando=0.
- State S_TEST:
  - Entered the cycle after Senal_MTest samples 1, from any state. Cooldown is cleared, Alimentando=0, and feed edges are ignored.
  - Each Senal_Paso rising edge decrements Nivel_Comida with wrap (0 -> 3) so a tester can cycle all levels.
  - Cuenta_Decaimiento is held.
  - Leaving: when Senal_MTest samples 0, go to S_RUN. Prescaler=0, Cuenta_Decaimiento reloads DECAY_SECS, level is kept.
- Senal_Paso is ignored outside S_TEST.
- Arithmetic: every update saturates or wraps explicitly as stated. There is no 2-bit overflow in any other path.
- Reset asserted mid-operation (any state, including S_FEED) returns everything to reset values immediately.

Test Plan (TICK_DIV=4, DECAY_SECS=3, FEED_COOLDOWN=2):
1. Release reset, no stimulus.
   - Pulso_Seg every 4 cycles.
   - Nivel_Comida goes 3 -> 2 after 12 cycles, ->1 at 24, ->0 at 36, then stays 0 at 48+.
   - Cuenta_Decaimiento steps 3, 2, 1, 3.
2. At Nivel_Comida=1, Activo_Comida=1, pulse Boton_Comida.
   - Nivel_Comida=2; Evento_Comida high for exactly 1 cycle.
   - Alimentando=1 for 2 ticks (about 8 cycles).
   - A second press inside that window is ignored (level stays 2, no event).
3. Activo_Comida=0, press Boton_Comida -> Nivel_Comida, Evento_Comida and Alimentando all unchanged.
4. Senal_MTest=1 from Nivel_Comida=3, four Senal_Paso pulses.
   - Level goes 2, 1, 0, 3; no decay over 100 idle cycles.
   - Drop Senal_MTest -> Cuenta_Decaimiento=3, and decay resumes 12 cycles later.
5. Feed edge aligned with the decay-completing tick at Nivel_Comida=2 -> Nivel_Comida=3, Cuenta_Decaimiento=3, S_FEED entered.
6. Assert reset mid-S_FEED with Boton_Comida held, release reset still holding.
   - Nivel_Comida=3, Alimentando=0, no Evento_Comida.
   - After the button is released and pressed again, the feed is accepted normally.
